// File: rtl/audio_i2s_tx.sv
// I2S transmitter for a codec-mastered link: oversamples BCLK/LRCLK on CLK_48 and
// shifts stereo PCM words out on SDATA from a one-deep valid/ready holding buffer.
module audio_i2s_tx #(
    parameter int SAMPLE_WIDTH = 24,
    parameter int SYNC_STAGES  = 2,
    parameter int WDOG_CYCLES  = 256
) (
    input  logic                    CLK_48,
    input  logic                    RESETN,
    input  logic                    BCLK,
    input  logic                    LRCLK,
    input  logic [SAMPLE_WIDTH-1:0] SAMPLE_L,
    input  logic [SAMPLE_WIDTH-1:0] SAMPLE_R,
    input  logic                    SAMPLE_VALID,
    output logic                    SAMPLE_READY,
    output logic                    SDATA,
    output logic                    FRAME_START,
    output logic                    UNDERRUN,
    output logic [15:0]             UNDERRUN_CNT
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    typedef enum logic {
        WAIT_SYNC,
        RUN
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lrclk_sync;
    logic                    bclk_hist;
    logic                    fall_p1;
    logic                    lr_now_p1;
    logic                    lr_prev;
    logic                    lr_edge;
    logic [WDOG_W-1:0]       wdog;
    logic                    wdog_trip;
    state_t                  state;
    logic                    buf_full;
    logic [SAMPLE_WIDTH-1:0] buf_l;
    logic [SAMPLE_WIDTH-1:0] buf_r;
    logic [SAMPLE_WIDTH-1:0] shreg;
    logic [SAMPLE_WIDTH-1:0] right_reg;
    logic [15:0]             underrun_cnt;
    logic                    accept;
    logic                    left_start;
    logic                    consume;

    // Stage p0: pin synchronizers and BCLK history
    always_ff @(posedge CLK_48 or negedge RESETN) begin
        if (!RESETN) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            bclk_hist  <= 1'b0;
            fall_p1    <= 1'b0;
            lr_now_p1  <= 1'b0;
        end else begin
            bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], BCLK};
            lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], LRCLK};
            bclk_hist  <= bclk_sync[SYNC_STAGES-1];
            // Stage p1: registered fall strobe with LRCLK captured on the same cycle
            fall_p1    <= bclk_hist & ~bclk_sync[SYNC_STAGES-1];
            lr_now_p1  <= lrclk_sync[SYNC_STAGES-1];
        end
    end

    assign lr_edge      = (lr_now_p1 != lr_prev);
    assign wdog_trip    = !fall_p1 && (wdog == WDOG_W'(WDOG_CYCLES - 1));
    assign accept       = SAMPLE_VALID && !buf_full;
    assign left_start   = fall_p1 && !wdog_trip && (state == RUN) && lr_edge && !lr_now_p1;
    // Only a full buffer can be consumed and only an empty one can accept, so the two never collide.
    assign consume      = left_start && buf_full;
    assign SAMPLE_READY = !buf_full;
    assign UNDERRUN_CNT = underrun_cnt;

    always_ff @(posedge CLK_48) begin
        if (accept) begin
            buf_l <= SAMPLE_L;
            buf_r <= SAMPLE_R;
        end
    end

    // Stage p2: slot sequencing, serializer, watchdog and handshake
    always_ff @(posedge CLK_48 or negedge RESETN) begin
        if (!RESETN) begin
            state        <= WAIT_SYNC;
            SDATA        <= 1'b0;
            FRAME_START  <= 1'b0;
            UNDERRUN     <= 1'b0;
            underrun_cnt <= '0;
            buf_full     <= 1'b0;
            shreg        <= '0;
            right_reg    <= '0;
            wdog         <= '0;
            lr_prev      <= 1'b0;
        end else begin
            FRAME_START <= 1'b0;
            UNDERRUN    <= 1'b0;

            if (consume) begin
                buf_full <= 1'b0;
            end else if (accept) begin
                buf_full <= 1'b1;
            end

            if (fall_p1) begin
                lr_prev <= lr_now_p1;
                wdog    <= '0;
            end else if (wdog != WDOG_W'(WDOG_CYCLES)) begin
                wdog <= wdog + WDOG_W'(1);
            end

            if (wdog_trip) begin
                state     <= WAIT_SYNC;
                SDATA     <= 1'b0;
                shreg     <= '0;
                right_reg <= '0;
            end else if (fall_p1) begin
                case (state)
                    WAIT_SYNC: begin
                        SDATA <= 1'b0;
                        if (lr_edge && lr_now_p1) begin
                            state <= RUN;
                        end
                    end
                    RUN: begin
                        if (lr_edge && !lr_now_p1) begin
                            SDATA       <= 1'b0;
                            FRAME_START <= 1'b1;
                            if (buf_full) begin
                                shreg     <= buf_l;
                                right_reg <= buf_r;
                            end else begin
                                shreg        <= '0;
                                right_reg    <= '0;
                                UNDERRUN     <= 1'b1;
                                underrun_cnt <= sat_inc16(underrun_cnt);
                            end
                        end else if (lr_edge) begin
                            SDATA <= 1'b0;
                            shreg <= right_reg;
                        end else begin
                            SDATA <= shreg[SAMPLE_WIDTH-1];
                            shreg <= {shreg[SAMPLE_WIDTH-2:0], 1'b0};
                        end
                    end
                    default: state <= WAIT_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Bench for audio_i2s_tx: drives codec-style BCLK/LRCLK and checks the serial stream
// and handshake against a slot/bit-position reference model.
module tb_audio_i2s_tx;

    localparam int SW   = 24;
    localparam int SS   = 2;
    localparam int WD   = 256;
    localparam int LAT  = SS + 2;
    localparam int HALF = 8;

    typedef struct {
        logic [SW-1:0] l;
        logic [SW-1:0] r;
    } pair_t;

    logic          CLK_48 = 1'b0;
    logic          RESETN;
    logic          BCLK;
    logic          LRCLK;
    logic [SW-1:0] SAMPLE_L;
    logic [SW-1:0] SAMPLE_R;
    logic          SAMPLE_VALID;
    logic          SAMPLE_READY;
    logic          SDATA;
    logic          FRAME_START;
    logic          UNDERRUN;
    logic [15:0]   UNDERRUN_CNT;

    audio_i2s_tx #(.SAMPLE_WIDTH(SW), .SYNC_STAGES(SS), .WDOG_CYCLES(WD)) dut (
        .CLK_48(CLK_48), .RESETN(RESETN), .BCLK(BCLK), .LRCLK(LRCLK),
        .SAMPLE_L(SAMPLE_L), .SAMPLE_R(SAMPLE_R), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_READY(SAMPLE_READY), .SDATA(SDATA), .FRAME_START(FRAME_START),
        .UNDERRUN(UNDERRUN), .UNDERRUN_CNT(UNDERRUN_CNT)
    );

    always #10 CLK_48 = ~CLK_48;

    int n_vec = 0;
    int n_err = 0;
    int obs_ur = 0;
    int obs_fs = 0;

    // Reference model state
    pair_t         pq[$];
    logic          m_run;
    logic          m_lrp;
    logic          m_full;
    logic [SW-1:0] m_bl, m_br;
    logic [SW-1:0] m_word, m_right;
    int            m_pos;
    logic [15:0]   m_cnt;
    logic          exp_fs, exp_ur;
    logic          last_sd;

    task automatic model_reset();
        m_run = 1'b0; m_lrp = 1'b0; m_full = 1'b0; m_cnt = 16'd0;
        m_word = '0; m_right = '0; m_pos = 0;
        exp_fs = 1'b0; exp_ur = 1'b0; last_sd = 1'b0;
        pq.delete();
        SAMPLE_VALID = 1'b0;
    endtask

    // One BCLK period (low then high), LRCLK changing with the falling edge.
    task automatic drive_bit(input logic lr);
        logic pre_full, accept, exp_sd, is_left;
        is_left = 1'b0;
        for (int k = 1; k <= 2 * HALF; k++) begin
            @(negedge CLK_48);
            n_vec++;
            if (SAMPLE_READY !== !m_full) begin
                n_err++; $display("FAIL ready: got %b want %b", SAMPLE_READY, !m_full);
            end
            n_vec++;
            if (FRAME_START !== exp_fs) begin
                n_err++; $display("FAIL frame_start: got %b want %b", FRAME_START, exp_fs);
            end
            n_vec++;
            if (UNDERRUN !== exp_ur) begin
                n_err++; $display("FAIL underrun: got %b want %b", UNDERRUN, exp_ur);
            end
            n_vec++;
            if (UNDERRUN_CNT !== m_cnt) begin
                n_err++; $display("FAIL underrun_cnt: got %h want %h", UNDERRUN_CNT, m_cnt);
            end
            if (UNDERRUN === 1'b1) obs_ur++;
            if (FRAME_START === 1'b1) obs_fs++;
            if (k == 1) begin
                BCLK = 1'b0;
                LRCLK = lr;
                if (!m_run) begin
                    if (lr != m_lrp && lr) begin
                        m_run = 1'b1; m_word = '0; m_pos = 0;
                    end
                end else if (lr != m_lrp && !lr) begin
                    is_left = 1'b1; m_pos = 0;
                end else if (lr != m_lrp) begin
                    m_word = m_right; m_pos = 0;
                end else begin
                    m_pos++;
                end
                m_lrp = lr;
            end
            if (k == HALF + 1) begin
                exp_sd = (!m_run || m_pos == 0 || m_pos > SW) ? 1'b0 : m_word[SW-m_pos];
                n_vec++;
                if (SDATA !== exp_sd) begin
                    n_err++; $display("FAIL sdata: pos %0d got %b want %b", m_pos, SDATA, exp_sd);
                end
                last_sd = exp_sd;
                BCLK = 1'b1;
            end
            SAMPLE_VALID = (pq.size() > 0);
            if (SAMPLE_VALID) begin
                SAMPLE_L = pq[0].l;
                SAMPLE_R = pq[0].r;
            end
            pre_full = m_full;
            accept = SAMPLE_VALID && !pre_full;
            exp_fs = 1'b0;
            exp_ur = 1'b0;
            if (is_left && k == LAT) begin
                exp_fs = 1'b1;
                if (pre_full) begin
                    m_word = m_bl; m_right = m_br; m_full = 1'b0;
                end else begin
                    m_word = '0; m_right = '0; exp_ur = 1'b1;
                    m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
                end
            end
            if (accept) begin
                m_full = 1'b1; m_bl = pq[0].l; m_br = pq[0].r;
                void'(pq.pop_front());
            end
        end
    endtask

    task automatic send_bits(input int n, input logic lr);
        for (int i = 0; i < n; i++) drive_bit(lr);
    endtask

    task automatic send_frame();
        send_bits(32, 1'b0);
        send_bits(32, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK_48);
            SAMPLE_VALID = 1'b0;
        end
    endtask

    task automatic push(input logic [SW-1:0] l, input logic [SW-1:0] r);
        pair_t p;
        p.l = l; p.r = r;
        pq.push_back(p);
    endtask

    task automatic pulse_reset();
        @(negedge CLK_48);
        RESETN = 1'b0;
        SAMPLE_VALID = 1'b0;
        #1;
        n_vec++;
        if (SDATA !== 1'b0) begin n_err++; $display("FAIL async_reset_sdata: got %b want 0", SDATA); end
        n_vec++;
        if (SAMPLE_READY !== 1'b1) begin n_err++; $display("FAIL async_reset_ready: got %b want 1", SAMPLE_READY); end
        n_vec++;
        if (UNDERRUN_CNT !== 16'd0) begin n_err++; $display("FAIL async_reset_cnt: got %h want 0", UNDERRUN_CNT); end
        model_reset();
        idle(3);
        n_vec++;
        if (FRAME_START !== 1'b0 || UNDERRUN !== 1'b0) begin
            n_err++; $display("FAIL reset_pulses: got fs=%b ur=%b want 0 0", FRAME_START, UNDERRUN);
        end
        RESETN = 1'b1;
        idle(4);
    endtask

    task automatic sync_up();
        send_bits(8, 1'b0);
        send_bits(32, 1'b1);
    endtask

    task automatic test_reset();
        BCLK = 1'b1; LRCLK = 1'b0; SAMPLE_L = '0; SAMPLE_R = '0; SAMPLE_VALID = 1'b0;
        RESETN = 1'b0;
        model_reset();
        idle(5);
        n_vec++;
        if (SDATA !== 1'b0 || FRAME_START !== 1'b0 || UNDERRUN !== 1'b0) begin
            n_err++; $display("FAIL reset_outputs: got sd=%b fs=%b ur=%b want 0 0 0", SDATA, FRAME_START, UNDERRUN);
        end
        n_vec++;
        if (SAMPLE_READY !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", SAMPLE_READY); end
        n_vec++;
        if (UNDERRUN_CNT !== 16'd0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", UNDERRUN_CNT); end
        RESETN = 1'b1;
        idle(4);
    endtask

    task automatic test_sync_after_reset();
        push(24'($urandom), 24'($urandom));
        send_bits(20, 1'b0);
        n_vec++;
        if (SAMPLE_READY !== 1'b0) begin n_err++; $display("FAIL wait_sync_buffer: got ready %b want 0", SAMPLE_READY); end
        send_bits(32, 1'b1);
        n_vec++;
        if (SAMPLE_READY !== 1'b0) begin n_err++; $display("FAIL first_right_slot_buffer: got ready %b want 0", SAMPLE_READY); end
        send_frame();
    endtask

    task automatic test_normal_frame();
        int fs0;
        pulse_reset();
        send_bits(8, 1'b0);
        push(24'hA5A5A5, 24'h3C3C3C);
        send_bits(32, 1'b1);
        fs0 = obs_fs;
        send_frame();
        send_frame();
        n_vec++;
        if (obs_fs - fs0 !== 2) begin n_err++; $display("FAIL frame_start_count: got %0d want 2", obs_fs - fs0); end
        n_vec++;
        if (UNDERRUN_CNT !== 16'd1) begin n_err++; $display("FAIL normal_underruns: got %0d want 1", UNDERRUN_CNT); end
    endtask

    task automatic test_underrun();
        int ur0;
        pulse_reset();
        sync_up();
        ur0 = obs_ur;
        for (int f = 0; f < 3; f++) send_frame();
        n_vec++;
        if (obs_ur - ur0 !== 3) begin n_err++; $display("FAIL underrun_pulses: got %0d want 3", obs_ur - ur0); end
        n_vec++;
        if (UNDERRUN_CNT !== 16'd3) begin n_err++; $display("FAIL underrun_cnt3: got %0d want 3", UNDERRUN_CNT); end
        @(negedge CLK_48);
        force dut.underrun_cnt = 16'hFFFD;
        @(negedge CLK_48);
        release dut.underrun_cnt;
        m_cnt = 16'hFFFD;
        for (int f = 0; f < 3; f++) send_frame();
        n_vec++;
        if (UNDERRUN_CNT !== 16'hFFFF) begin n_err++; $display("FAIL underrun_sat: got %h want ffff", UNDERRUN_CNT); end
    endtask

    task automatic test_back_to_back();
        send_frame();
        push(24'h111111, 24'h222222);
        push(24'($urandom), 24'($urandom));
        send_bits(32, 1'b1);
        n_vec++;
        if (SAMPLE_READY !== 1'b0 || SAMPLE_VALID !== 1'b1) begin
            n_err++; $display("FAIL backpressure: got ready=%b valid=%b want 0 1", SAMPLE_READY, SAMPLE_VALID);
        end
        send_frame();
        send_frame();
    endtask

    task automatic test_random_stream();
        for (int s = 0; s < 14; s++) begin
            if ($urandom_range(0, 1) == 1) push(24'($urandom), 24'($urandom));
            send_bits(int'($urandom_range(20, 34)), s[0]);
        end
    endtask

    task automatic test_watchdog();
        send_frame();
        push(24'hFFFFFF, 24'h800001);
        push(24'hDEADBE, 24'h5A5A5A);
        send_bits(12, 1'b0);
        for (int c = 1; c <= 300; c++) begin
            @(negedge CLK_48);
            SAMPLE_VALID = 1'b0;
            if (c == 200) begin
                n_vec++;
                if (SDATA !== last_sd) begin n_err++; $display("FAIL wdog_early: got %b want %b", SDATA, last_sd); end
            end
        end
        m_run = 1'b0; m_word = '0; m_right = '0;
        n_vec++;
        if (SDATA !== 1'b0) begin n_err++; $display("FAIL wdog_sdata: got %b want 0", SDATA); end
        n_vec++;
        if (SAMPLE_READY !== 1'b0) begin n_err++; $display("FAIL wdog_buffer_kept: got ready %b want 0", SAMPLE_READY); end
        send_bits(20, 1'b0);
        send_bits(32, 1'b1);
        send_frame();
    endtask

    task automatic test_reset_mid_slot();
        push(24'hA5A5A5, 24'h3C3C3C);
        send_frame();
        send_bits(10, 1'b0);
        pulse_reset();
        send_bits(10, 1'b0);
        send_bits(32, 1'b1);
        push(24'($urandom), 24'($urandom));
        send_frame();
        send_frame();
    endtask

    initial begin
        test_reset();
        test_sync_after_reset();
        test_normal_frame();
        test_underrun();
        test_back_to_back();
        test_random_stream();
        test_watchdog();
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
